trigger_source_conditioner: RTL and testbench



---
 rtl/trigger_source_conditioner.sv | 144 ++++++++++++++
 tb/tb_trigger_source_conditioner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_source_conditioner.sv
// rtl/trigger_source_conditioner.sv - trigger source select, debounce and edge pulse generator
// Optional interval measurement is built when TRIGGER_INTERVAL_EN is defined.
module trigger_source_conditioner #(
    parameter int ADC_WIDTH      = 16,
    parameter int DEBOUNCE_WIDTH = 8,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [7:0]                  dios,
    input  logic signed [ADC_WIDTH-1:0] adc0,
    input  logic signed [ADC_WIDTH-1:0] adc1,
    input  logic [4:0]                  source_select,
    input  logic signed [ADC_WIDTH-1:0] adc_threshold,
    input  logic [ADC_WIDTH-1:0]        adc_hysteresis,
    input  logic [DEBOUNCE_WIDTH-1:0]   debounce_cycles,
    input  logic                        edge_polarity,
    output logic                        source_level,
    output logic                        source_pulse,
    output logic [COUNT_WIDTH-1:0]      pulse_count,
    output logic [COUNT_WIDTH-1:0]      last_interval,
    output logic                        interval_valid
);

    localparam int XW = ADC_WIDTH + 2;

    logic [7:0]                dio_s1;
    logic [7:0]                dio_s2;
    logic                      cmp0;
    logic                      cmp1;
    logic                      raw;
    logic [4:0]                sel_q;
    logic [DEBOUNCE_WIDTH-1:0] dcnt;
    logic [DEBOUNCE_WIDTH-1:0] dcnt_next;
    logic                      stable_next;
    logic                      switching;
    logic                      changed_q;
    logic                      fire;

    // Two guard bits keep threshold +/- hysteresis exact for any input values
    logic signed [XW-1:0] thr_x, hyst_x, band_hi, band_lo, adc0_x, adc1_x;
    assign thr_x   = {{2{adc_threshold[ADC_WIDTH-1]}}, adc_threshold};
    assign hyst_x  = {2'b00, adc_hysteresis};
    assign adc0_x  = {{2{adc0[ADC_WIDTH-1]}}, adc0};
    assign adc1_x  = {{2{adc1[ADC_WIDTH-1]}}, adc1};
    assign band_hi = thr_x + hyst_x;
    assign band_lo = thr_x - hyst_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dio_s1 <= '0;
            dio_s2 <= '0;
            cmp0   <= 1'b0;
            cmp1   <= 1'b0;
        end else begin
            dio_s1 <= dios;
            dio_s2 <= dio_s1;
            if (adc0_x > band_hi)
                cmp0 <= 1'b1;
            else if (adc0_x < band_lo)
                cmp0 <= 1'b0;
            if (adc1_x > band_hi)
                cmp1 <= 1'b1;
            else if (adc1_x < band_lo)
                cmp1 <= 1'b0;
        end
    end

    always_comb begin
        raw = 1'b0;
        if (source_select[4:3] == 2'b00)
            raw = dio_s2[source_select[2:0]];
        else if (source_select == 5'd8)
            raw = cmp0;
        else if (source_select == 5'd9)
            raw = cmp1;
    end

    // A source change loads the new level outright so it never reads as an edge
    always_comb begin
        switching   = (sel_q != source_select);
        stable_next = source_level;
        dcnt_next   = dcnt;
        if (switching) begin
            stable_next = raw;
            dcnt_next   = '0;
        end else if (raw == source_level) begin
            dcnt_next = '0;
        end else if (dcnt >= debounce_cycles) begin
            stable_next = raw;
            dcnt_next   = '0;
        end else begin
            dcnt_next = dcnt + 1'b1;
        end
    end

    assign fire = enable && changed_q && (source_level != edge_polarity) && !source_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q        <= '0;
            source_level <= 1'b0;
            dcnt         <= '0;
            changed_q    <= 1'b0;
            source_pulse <= 1'b0;
            pulse_count  <= '0;
        end else begin
            sel_q        <= source_select;
            source_level <= stable_next;
            dcnt         <= dcnt_next;
            changed_q    <= !switching && (stable_next != source_level);
            source_pulse <= fire;
            if (fire)
                pulse_count <= pulse_count + 1'b1;
        end
    end

`ifdef TRIGGER_INTERVAL_EN
    logic [COUNT_WIDTH-1:0] icnt;
    logic                   seen_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt           <= '0;
            seen_pulse     <= 1'b0;
            last_interval  <= '0;
            interval_valid <= 1'b0;
        end else if (fire) begin
            last_interval <= icnt;
            icnt          <= COUNT_WIDTH'(1);
            seen_pulse    <= 1'b1;
            if (seen_pulse)
                interval_valid <= 1'b1;
        end else if (enable && (icnt != '1)) begin
            icnt <= icnt + 1'b1;
        end
    end
`else
    assign last_interval  = '0;
    assign interval_valid = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_source_conditioner.sv
// tb/tb_trigger_source_conditioner.sv - scoreboard bench for trigger_source_conditioner
module tb_trigger_source_conditioner;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int CW = 32;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic [7:0]           dios = '0;
    logic signed [AW-1:0] adc0 = '0;
    logic signed [AW-1:0] adc1 = '0;
    logic [4:0]           source_select = '0;
    logic signed [AW-1:0] adc_threshold = '0;
    logic [AW-1:0]        adc_hysteresis = '0;
    logic [DW-1:0]        debounce_cycles = '0;
    logic                 edge_polarity = 1'b0;
    logic                 source_level;
    logic                 source_pulse;
    logic [CW-1:0]        pulse_count;
    logic [CW-1:0]        last_interval;
    logic                 interval_valid;

    trigger_source_conditioner #(.ADC_WIDTH(AW), .DEBOUNCE_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dios(dios), .adc0(adc0), .adc1(adc1),
        .source_select(source_select), .adc_threshold(adc_threshold),
        .adc_hysteresis(adc_hysteresis), .debounce_cycles(debounce_cycles),
        .edge_polarity(edge_polarity), .source_level(source_level),
        .source_pulse(source_pulse), .pulse_count(pulse_count),
        .last_interval(last_interval), .interval_valid(interval_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        lvl;
        bit [31:0] cnt;
        bit [31:0] li;
        bit        iv;
    } cyc_t;

    cyc_t cyc_q[$];
    int   pulse_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_n = 0;

    // Reference model: level after each edge, expected pulse edges, counters
    bit [7:0]  dio_hist[$];
    bit        m_cmp0, m_cmp1, m_level, m_chg, m_pulse;
    int        m_run;
    bit [4:0]  m_sel;
    bit [31:0] m_cnt, m_li;
    bit        m_iv;
`ifdef TRIGGER_INTERVAL_EN
    bit [31:0] m_icnt;
    bit        m_seen;
`endif

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void model_reset();
        dio_hist = '{8'h00, 8'h00};
        m_cmp0 = 0; m_cmp1 = 0; m_level = 0; m_chg = 0; m_pulse = 0;
        m_run = 0; m_sel = 0; m_cnt = 0; m_li = 0; m_iv = 0;
`ifdef TRIGGER_INTERVAL_EN
        m_icnt = 0; m_seen = 0;
`endif
    endfunction

    function automatic bit cmp_next(input bit st, input int x);
        int hi;
        int lo;
        hi = int'(adc_threshold) + int'({16'h0, adc_hysteresis});
        lo = int'(adc_threshold) - int'({16'h0, adc_hysteresis});
        if (x > hi) return 1'b1;
        if (x < lo) return 1'b0;
        return st;
    endfunction

    function automatic void m_edge();
        bit       raw;
        bit       fire;
        bit       nl;
        bit       sw;
        bit [7:0] d;
        edge_n++;
        if (reset) begin
            model_reset();
        end else begin
            d = dio_hist[0];
            raw = 1'b0;
            if (source_select < 5'd8) raw = d[source_select[2:0]];
            else if (source_select == 5'd8) raw = m_cmp0;
            else if (source_select == 5'd9) raw = m_cmp1;
            fire = enable && m_chg && (m_level == !edge_polarity) && !m_pulse;
            sw = (m_sel != source_select);
            nl = m_level;
            // a new level is accepted once debounce_cycles+1 disagreeing samples in a row are seen
            if (sw) begin
                nl = raw;
                m_run = 0;
            end else if (raw == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run > int'(debounce_cycles)) begin
                    nl = raw;
                    m_run = 0;
                end
            end
            m_chg = !sw && (nl != m_level);
            m_level = nl;
            m_sel = source_select;
            m_cmp0 = cmp_next(m_cmp0, int'(adc0));
            m_cmp1 = cmp_next(m_cmp1, int'(adc1));
            dio_hist.push_back(dios);
            void'(dio_hist.pop_front());
            if (fire) begin
                m_cnt++;
                pulse_q.push_back(edge_n);
            end
`ifdef TRIGGER_INTERVAL_EN
            if (fire) begin
                m_li = m_icnt;
                m_icnt = 1;
                if (m_seen) m_iv = 1;
                m_seen = 1;
            end else if (enable && m_icnt != 32'hFFFF_FFFF) begin
                m_icnt++;
            end
`endif
            m_pulse = fire;
        end
        cyc_q.push_back('{m_level, m_cnt, m_li, m_iv});
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: pops the expected state for every cycle and the expected pulse edges
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (cyc_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL cycle_queue: got empty expected one entry (edge %0d)", edge_n);
            end else begin
                e = cyc_q.pop_front();
                chk("source_level", source_level, e.lvl);
                chk("pulse_count", pulse_count, e.cnt);
                chk("last_interval", last_interval, e.li);
                chk("interval_valid", interval_valid, e.iv);
            end
            if (source_pulse) begin
                if (pulse_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pulse: got pulse expected none (edge %0d)", edge_n);
                end else begin
                    chk("pulse_edge", edge_n, pulse_q.pop_front());
                end
            end else if (pulse_q.size() > 0 && pulse_q[0] <= edge_n) begin
                n_checks++; n_fail++;
                $display("FAIL missed_pulse: got none expected pulse at edge %0d", pulse_q.pop_front());
            end
        end
    end

    task automatic dio_edge_check();
        source_select = 0; debounce_cycles = 0; edge_polarity = 0; enable = 1; dios = 0;
        ticks(4);
        dios[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dio_pulse_early", source_pulse, 0);
        end
        tick();
        chk("dio_pulse_edge3", source_pulse, 1);
        chk("dio_count_1", pulse_count, 1);
        chk("dio_level_1", source_level, 1);
        tick();
        chk("dio_pulse_single", source_pulse, 0);
    endtask

    task automatic adc_seq(input string tag, input logic [1:0] exp_lv [4]);
        int samples [4];
        samples = '{1050, 1101, 1000, 899};
        for (int i = 0; i < 4; i++) begin
            adc0 = 16'(samples[i]);
            ticks(3);
            chk(tag, source_level, exp_lv[i]);
        end
    endtask

    initial begin
        bit [31:0]  c0;
        logic [1:0] lv [4];
        model_reset();
        #1;
        chk("rst_level", source_level, 0);
        chk("rst_pulse", source_pulse, 0);
        chk("rst_count", pulse_count, 0);
        chk("rst_interval", last_interval, 0);
        chk("rst_ivalid", interval_valid, 0);
        ticks(2);
        reset = 0;

        dio_edge_check();

        // glitch rejection on dios[3]
        source_select = 3; debounce_cycles = 4; dios = 0;
        ticks(8);
        c0 = m_cnt;
        dios[3] = 1; ticks(4); dios[3] = 0; ticks(10);
        chk("glitch_4_rejected", pulse_count, c0);
        dios[3] = 1; ticks(5); dios[3] = 0; ticks(14);
        chk("glitch_5_accepted", pulse_count, c0 + 1);

        // ADC hysteresis, rising then falling polarity
        source_select = 8; debounce_cycles = 0; adc_threshold = 1000; adc_hysteresis = 100;
        adc0 = 0; ticks(5);
        lv = '{0, 1, 1, 0};
        c0 = m_cnt;
        adc_seq("adc_level_rise", lv);
        ticks(2);
        chk("adc_rise_pulse", pulse_count, c0 + 1);
        edge_polarity = 1; adc0 = 0; ticks(4);
        adc_seq("adc_level_fall", lv);
        ticks(2);
        chk("adc_fall_pulse", pulse_count, c0 + 2);
        edge_polarity = 0;

        // band edges at the extremes of the sample range
        adc_threshold = 16'sh7FFF; adc_hysteresis = 1; adc0 = 16'sh7FFF; ticks(4);
        chk("adc_top_edge", source_level, 0);
        adc_threshold = 16'sh7FFF; adc_hysteresis = 16'hFFFF; adc0 = -16'sd32768; ticks(4);
        chk("adc_wide_band_hold", source_level, 0);

        // pulses 250 clocks apart
        source_select = 0; dios = 0; ticks(6);
        for (int k = 0; k < 4; k++) begin
            dios[0] = 1; ticks(125);
            dios[0] = 0; ticks(125);
        end
`ifdef TRIGGER_INTERVAL_EN
        chk("interval_250", last_interval, 250);
        chk("interval_valid_set", interval_valid, 1);
`endif

        // source switch and enable
        dios = 8'b0000_0001; source_select = 0; ticks(6);
        c0 = m_cnt;
        source_select = 1; ticks(5);
        chk("switch_level", source_level, 0);
        source_select = 0; ticks(5);
        chk("switch_no_pulse", pulse_count, c0);
        enable = 0; dios = 0; ticks(6);
        dios[0] = 1; ticks(6);
        chk("disabled_level", source_level, 1);
        chk("disabled_no_pulse", pulse_count, c0);
        enable = 1;

        // randomized mix
        adc_threshold = 1000; adc_hysteresis = 80;
        for (int i = 0; i < 4000; i++) begin
            dios = dios ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 149) == 0) source_select = 5'($urandom_range(0, 11));
            if ($urandom_range(0, 99) == 0) debounce_cycles = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) edge_polarity = ~edge_polarity;
            if ($urandom_range(0, 299) == 0) adc_hysteresis = 16'($urandom_range(0, 150));
            enable = ($urandom_range(0, 9) != 0);
            if (i % 3 == 0) begin
                adc0 = 16'(1000 + int'($urandom_range(0, 400)) - 200);
                adc1 = 16'(1000 + int'($urandom_range(0, 400)) - 200);
            end
            tick();
        end

        // reset in the middle of a debounce count
        enable = 1; source_select = 0; debounce_cycles = 6; edge_polarity = 0; dios = 0;
        ticks(10);
        dios[0] = 1; ticks(4);
        #2 reset = 1;
        #1;
        chk("midrst_level", source_level, 0);
        chk("midrst_pulse", source_pulse, 0);
        chk("midrst_count", pulse_count, 0);
        chk("midrst_interval", last_interval, 0);
        chk("midrst_ivalid", interval_valid, 0);
        ticks(2);
        reset = 0;
        dio_edge_check();
        ticks(3);

        #1;
        chk("pending_pulses", pulse_q.size(), 0);
        chk("pending_cycles", cyc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
